// File: rtl/alu_pkg.sv
// Shared constants and types for the execute-stage ALU: control codes,
// default widths and the FSM state encoding.
package alu_pkg;

  localparam int DEF_XLEN    = 32;
  localparam int DEF_SHAMT_W = 5;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SLL   = 4'b0011;
  localparam logic [3:0] ALU_SLTU  = 4'b0100;
  localparam logic [3:0] ALU_SLT   = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_XOR   = 4'b0111;
  localparam logic [3:0] ALU_SRL   = 4'b1000;
  localparam logic [3:0] ALU_PASSB = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic is_shift_op(input logic [3:0] ctrl);
    return (ctrl == ALU_SLL) || (ctrl == ALU_SRL) || (ctrl == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// One-bit shift step for SLL/SRL/SRA; the iterative shifter applies it once
// per cycle to the working register.
module alu_shift_step
  import alu_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] value,
  output logic [XLEN-1:0] next_value
);

  always_comb begin
    next_value = value;
    case (op)
      ALU_SLL: next_value = {value[XLEN-2:0], 1'b0};
      ALU_SRL: next_value = {1'b0, value[XLEN-1:1]};
      ALU_SRA: next_value = {value[XLEN-1], value[XLEN-1:1]};
      default: next_value = value;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake. Logic/arithmetic ops finish
// in one cycle; shifts iterate one bit per cycle from a latched operand.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | in_ready high, waiting for in_valid
// ST_SHIFT | iterating the latched shift, counter counts down to 1
// ST_DONE  | out_valid high, result held until out_ready
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int XLEN    = DEF_XLEN,
  parameter int SHAMT_W = DEF_SHAMT_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [SHAMT_W-1:0] CNT_ONE = SHAMT_W'(1);

  state_t            state_q, state_d;
  logic [3:0]        ctrl_q, ctrl_d;
  logic [XLEN-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              illegal_q, illegal_d;

  logic [XLEN-1:0]   alu_res;
  logic              alu_legal;
  logic [XLEN-1:0]   step_val;
  logic [SHAMT_W-1:0] shamt;

  assign shamt = op_b[SHAMT_W-1:0];

  // Single-cycle datapath; a shift that reaches here has shamt==0 so it passes op_a.
  always_comb begin
    alu_res   = '0;
    alu_legal = 1'b1;
    case (alu_ctrl)
      ALU_AND:   alu_res = op_a & op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      ALU_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      ALU_PASSB: alu_res = op_b;
      ALU_SLL, ALU_SRL, ALU_SRA: alu_res = op_a;
      default: begin
        alu_res   = '0;
        alu_legal = 1'b0;
      end
    endcase
  end

  alu_shift_step #(.XLEN(XLEN)) u_shift_step (
    .op         (ctrl_q),
    .value      (work_q),
    .next_value (step_val)
  );

  always_comb begin
    state_d   = state_q;
    ctrl_d    = ctrl_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    result_d  = result_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          ctrl_d = alu_ctrl;
          work_d = op_a;
          cnt_d  = shamt;
          if (is_shift_op(alu_ctrl) && (shamt != '0)) begin
            state_d = ST_SHIFT;
          end else begin
            state_d   = ST_DONE;
            result_d  = alu_res;
            zero_d    = (alu_res == '0);
            illegal_d = ~alu_legal;
          end
        end
      end
      ST_SHIFT: begin
        work_d = step_val;
        cnt_d  = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d   = ST_DONE;
          result_d  = step_val;
          zero_d    = (step_val == '0);
          illegal_d = 1'b0;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      ctrl_q    <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      result_q  <= '0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign zero      = zero_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed scenarios plus randomized
// operations compared against a behavioural reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int errors = 0;
  int checks = 0;

  localparam int MAX_LAT = 80;

  alu_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_ctrl  (alu_ctrl),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [3:0] c, input logic [31:0] a,
                                             input logic [31:0] b);
    int sh;
    logic signed [31:0] sa;
    sh = int'(b % 32);
    sa = a;
    case (c)
      4'd0:  return a & b;
      4'd1:  return a | b;
      4'd2:  return a + b;
      4'd3:  return a << sh;
      4'd4:  return (a < b) ? 32'd1 : 32'd0;
      4'd5:  return (sa < $signed(b)) ? 32'd1 : 32'd0;
      4'd6:  return a - b;
      4'd7:  return a ^ b;
      4'd8:  return a >> sh;
      4'd9:  return b;
      4'd10: return sa >>> sh;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [3:0] c, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    if ((c == 4'd3 || c == 4'd8 || c == 4'd10) && sh != 0) return sh + 1;
    return 1;
  endfunction

  // Drives one request with out_ready high; starts and ends just after a negedge.
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                        input bit noisy, output int lat, output logic [31:0] res,
                        output logic z, output logic il, output bit busy_ready,
                        output bit post_idle);
    in_valid  = 1'b1;
    alu_ctrl  = c;
    op_a      = a;
    op_b      = b;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    if (noisy) begin
      op_a     = $urandom;
      op_b     = $urandom;
      alu_ctrl = 4'($urandom_range(0, 15));
    end else begin
      in_valid = 1'b0;
    end
    lat = 1;
    busy_ready = 1'b0;
    @(negedge clk);
    while (!out_valid && lat < MAX_LAT) begin
      if (in_ready) busy_ready = 1'b1;
      @(negedge clk);
      lat++;
    end
    if (in_ready) busy_ready = 1'b1;
    res = result;
    z   = zero;
    il  = illegal;
    in_valid = 1'b0;
    @(negedge clk);
    post_idle = in_ready && !out_valid;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, zero, illegal} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_flags: got rdy/vld/zero/ill=%b expected 1000",
               {in_ready, out_valid, zero, illegal});
    end
    checks++;
    if (result !== 32'd0) begin
      errors++;
      $display("FAIL reset_result: got %h expected 00000000", result);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed(input string name, input logic [3:0] c, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_res,
                               input logic exp_z, input logic exp_il, input int exp_lat);
    int lat;
    logic [31:0] res;
    logic z, il;
    bit busy, idle;
    run_op(c, a, b, 1'b1, lat, res, z, il, busy, idle);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s_latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if ({res, z, il} !== {exp_res, exp_z, exp_il}) begin
      errors++;
      $display("FAIL %s_result: got %h z=%b ill=%b expected %h z=%b ill=%b",
               name, res, z, il, exp_res, exp_z, exp_il);
    end
    checks++;
    if (busy || !idle) begin
      errors++;
      $display("FAIL %s_ready: got ready_while_busy=%b idle_after=%b expected 0 and 1",
               name, busy, idle);
    end
  endtask

  task automatic test_backpressure();
    in_valid  = 1'b1;
    alu_ctrl  = 4'b1001;
    op_a      = 32'h1234_5678;
    op_b      = 32'hDEAD_BEEF;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op_b     = 32'h0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, in_ready, zero, illegal} !== 4'b1000 || result !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL backpressure_hold%0d: got vld/rdy/z/ill=%b result=%h expected 1000 deadbeef",
                 i, {out_valid, in_ready, zero, illegal}, result);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL backpressure_release: got vld/rdy=%b expected 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid_op();
    bit saw_valid;
    saw_valid = 1'b0;
    in_valid  = 1'b1;
    alu_ctrl  = 4'b0011;
    op_a      = 32'h0000_0003;
    op_b      = 32'd10;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, in_ready} !== 2'b01 || result !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_op_state: got vld/rdy=%b result=%h expected 01 00000000",
               {out_valid, in_ready}, result);
    end
    rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    checks++;
    if (saw_valid) begin
      errors++;
      $display("FAIL reset_mid_op_no_valid: got out_valid pulse expected none");
    end
    test_directed("add_after_reset", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);
  endtask

  task automatic test_random(input int n);
    int lat;
    logic [3:0]  c;
    logic [31:0] a, b, res, exp;
    logic z, il;
    bit busy, idle, noisy;
    for (int i = 0; i < n; i++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 31)) : $urandom;
      if ($urandom_range(0, 3) == 0) b = a;
      noisy = 1'($urandom_range(0, 1));
      exp = ref_result(c, a, b);
      run_op(c, a, b, noisy, lat, res, z, il, busy, idle);
      checks++;
      if ({res, z, il} !== {exp, (exp == 32'd0), (c > 4'd10)} ||
          lat !== ref_latency(c, b) || busy || !idle) begin
        errors++;
        $display("FAIL random%0d ctrl=%h a=%h b=%h: got %h z=%b ill=%b lat=%0d busy=%b idle=%b expected %h z=%b ill=%b lat=%0d",
                 i, c, a, b, res, z, il, lat, busy, idle, exp, (exp == 32'd0), (c > 4'd10),
                 ref_latency(c, b));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_directed("add_ovf",  4'b0010, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1);
    test_directed("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1);
    test_directed("slt",      4'b0101, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    test_directed("sltu",     4'b0100, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    test_directed("sra4",     4'b1010, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 5);
    test_directed("sll31",    4'b0011, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 32);
    test_directed("srl0",     4'b1000, 32'hA5A5_0F0F, 32'hFFFF_FFE0, 32'hA5A5_0F0F, 1'b0, 1'b0, 1);
    test_directed("srl31",    4'b1000, 32'h8000_0000, 32'd31, 32'd1, 1'b0, 1'b0, 32);
    test_backpressure();
    test_directed("illegal",  4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1'b1, 1'b1, 1);
    test_reset_mid_op();
    test_random(60);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
